// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point add/subtract: align -> add -> normalise/round, one op per cycle.
// Latency 3 cycles; all stages stall together while an output result is held unaccepted.
module fp_addsub_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow
);
  localparam int MW      = MAN_W + 4;  // {hidden, frac, G, R, S}
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: order operands and align ----------------
  logic             sa, sb, a_big, xs, ys, sticky, z1;
  logic [EXP_W-1:0] ea, eb, xe, ye;
  logic [MAN_W-1:0] xf, yf;
  logic [31:0]      d;
  logic [MW-1:0]    x_ext, y_ext, y_sh, y_al;
  logic [W-1:0]     zres1;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ op;
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];

  always_comb begin
    a_big  = (a[W-2:0] >= b[W-2:0]);
    xs     = a_big ? sa : sb;
    ys     = a_big ? sb : sa;
    xe     = a_big ? ea : eb;
    ye     = a_big ? eb : ea;
    xf     = a_big ? a[MAN_W-1:0] : b[MAN_W-1:0];
    yf     = a_big ? b[MAN_W-1:0] : a[MAN_W-1:0];
    d      = 32'(xe) - 32'(ye);
    x_ext  = {1'b1, xf, 3'b000};
    y_ext  = {1'b1, yf, 3'b000};
    y_sh   = y_ext >> d;
    sticky = |(y_ext & ~({MW{1'b1}} << d));
    // Far-out operand survives only as a sticky bit
    y_al   = (d >= 32'(MW)) ? {{(MW-1){1'b0}}, 1'b1} : {y_sh[MW-1:1], y_sh[0] | sticky};
    z1     = (ea == '0) || (eb == '0);
    if ((ea == '0) && (eb == '0)) zres1 = {sa & sb, {(W-1){1'b0}}};
    else if (ea == '0)            zres1 = {sb, b[W-2:0]};
    else                          zres1 = a;
  end

  logic             s1_vld, s1_zero, s1_sign, s1_sub;
  logic [W-1:0]     s1_zres;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_xm, s1_ym;

  // ---------------- stage 2: magnitude add / subtract ----------------
  logic [MW:0] m2;
  assign m2 = s1_sub ? ({1'b0, s1_xm} - {1'b0, s1_ym}) : ({1'b0, s1_xm} + {1'b0, s1_ym});

  logic             s2_vld, s2_zero, s2_sign;
  logic [W-1:0]     s2_zres;
  logic [EXP_W-1:0] s2_exp;
  logic [MW:0]      s2_m;

  // ---------------- stage 3: normalise, round, saturate --------------
  logic [MW-1:0]    norm;
  int               lz, e_pre, e_fin;
  logic             rnd, rcarry, ov3, uf3;
  logic [MAN_W-1:0] frac_r;
  logic [W-1:0]     res3;

  always_comb begin
    lz = 0;
    for (int i = 0; i < MW; i++)
      if (s2_m[i]) lz = MW - 1 - i;
    if (s2_m[MW]) begin
      norm  = {s2_m[MW:2], s2_m[1] | s2_m[0]};
      e_pre = int'(s2_exp) + 1;
    end else begin
      norm  = s2_m[MW-1:0] << lz;
      e_pre = int'(s2_exp) - lz;
    end
    rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
    frac_r = norm[MW-2:3] + MAN_W'(rnd);
    rcarry = rnd & (&norm[MW-2:3]);
    e_fin  = e_pre + (rcarry ? 1 : 0);
    res3   = {s2_sign, EXP_W'(e_fin), frac_r};
    ov3    = 1'b0;
    uf3    = 1'b0;
    // No hidden bit after normalising means exact cancellation: +0, no flags
    if (s2_zero)            res3 = s2_zres;
    else if (!norm[MW-1])   res3 = '0;
    else if (e_pre < 1) begin
      res3 = {s2_sign, {(W-1){1'b0}}};
      uf3  = 1'b1;
    end else if (e_fin > EXP_MAX) begin
      res3 = {s2_sign, {(W-1){1'b1}}};
      ov3  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sub    <= 1'b0;
      s1_zres   <= '0;
      s1_exp    <= '0;
      s1_xm     <= '0;
      s1_ym     <= '0;
      s2_vld    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zres   <= '0;
      s2_exp    <= '0;
      s2_m      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (adv) begin
      s1_vld    <= in_valid;
      s1_zero   <= z1;
      s1_sign   <= xs;
      s1_sub    <= xs ^ ys;
      s1_zres   <= zres1;
      s1_exp    <= xe;
      s1_xm     <= x_ext;
      s1_ym     <= y_al;
      s2_vld    <= s1_vld;
      s2_zero   <= s1_zero;
      s2_sign   <= s1_sign;
      s2_zres   <= s1_zres;
      s2_exp    <= s1_exp;
      s2_m      <= m2;
      out_valid <= s2_vld;
      result    <= res3;
      overflow  <= ov3;
      underflow <= uf3;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe: arithmetic table, back-pressure stream, mid-flight reset.
module tb_fp_addsub_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       op = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] res;
    logic       ov;
    logic       uf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(4), .MAN_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .underflow(underflow)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input int i);
    a  = vecs[i].a;
    b  = vecs[i].b;
    op = vecs[i].op;
  endtask

  // Single operation: checks acceptance, 3-cycle latency, result and flags
  task automatic run_one(input int i);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    drive(i);
    #1;
    chk("vec_in_ready", i, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("vec_latency", i, lat, 3);
    chk("vec_result", i, result, vecs[i].res);
    chk("vec_overflow", i, overflow, vecs[i].ov);
    chk("vec_underflow", i, underflow, vecs[i].uf);
  endtask

  task automatic backpressure();
    int sel[5] = '{0, 1, 4, 7, 10};
    int out_cyc[5] = '{0, 0, 0, 0, 0};
    int issued = 0;
    int got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = (c < 2) || (c >= 12);
      if (issued < 5) begin
        in_valid = 1'b1;
        drive(sel[issued]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_in_ready_stall", c, in_ready, 0);
        if (got < 5) chk("bp_hold", c, result, vecs[sel[got]].res);
      end
      if (out_valid && out_ready) begin
        if (got < 5) begin
          chk("bp_result", got, result, vecs[sel[got]].res);
          chk("bp_overflow", got, overflow, vecs[sel[got]].ov);
          out_cyc[got] = c;
        end else begin
          checks++;
          errors++;
          $display("FAIL bp_extra_output[%0d]: got result %0h, expected no output", c, result);
        end
        got++;
      end
      if (in_valid && in_ready) issued++;
    end
    in_valid = 1'b0;
    chk("bp_issued", 0, issued, 5);
    chk("bp_count", 0, got, 5);
    chk("bp_first_out_cycle", 0, out_cyc[0], 12);
    chk("bp_burst_span", 0, out_cyc[4] - out_cyc[0], 4);
  endtask

  task automatic reset_mid();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      drive(k == 0 ? 7 : (k == 1 ? 1 : 4));
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", 0, out_valid, 1);
    chk("pre_rst_result", 0, result, 8'h7F);
    chk("pre_rst_overflow", 0, overflow, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 0, out_valid, 0);
    chk("mid_rst_result", 0, result, 0);
    chk("mid_rst_overflow", 0, overflow, 0);
    chk("mid_rst_underflow", 0, underflow, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_idle", k, out_valid, 0);
      chk("post_rst_in_ready", k, in_ready, 1);
    end
    run_one(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    //          a      b      op    res    ov    uf
    vecs[0]  = '{8'h28, 8'h28, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[1]  = '{8'h2C, 8'h2B, 1'b1, 8'h10, 1'b0, 1'b0};
    vecs[2]  = '{8'h0C, 8'h0B, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{8'h2B, 8'h2B, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'h20, 8'h0F, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[5]  = '{8'h20, 8'h0C, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[6]  = '{8'h28, 8'h08, 1'b0, 8'h28, 1'b0, 1'b0};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 8'hAB, 1'b0, 8'hAB, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 8'hAB, 1'b1, 8'h2B, 1'b0, 1'b0};
    vecs[10] = '{8'h30, 8'h28, 1'b1, 8'h28, 1'b0, 1'b0};
    vecs[11] = '{8'hA8, 8'h30, 1'b0, 8'h28, 1'b0, 1'b0};
    vecs[12] = '{8'h35, 8'h00, 1'b1, 8'h35, 1'b0, 1'b0};
    vecs[13] = '{8'h80, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[14] = '{8'h50, 8'h08, 1'b0, 8'h50, 1'b0, 1'b0};
    vecs[15] = '{8'h7F, 8'h58, 1'b0, 8'h7F, 1'b1, 1'b0};
    vecs[16] = '{8'h8C, 8'h8B, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[17] = '{8'h28, 8'hA8, 1'b1, 8'h30, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 0, out_valid, 0);
    chk("rst_result", 0, result, 0);
    chk("rst_overflow", 0, overflow, 0);
    chk("rst_underflow", 0, underflow, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 0, in_ready, 1);

    for (int i = 0; i < NV; i++) run_one(i);
    backpressure();
    reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined floating-point adder/subtractor. Successor to the 8-bit combinational fp adder.
- Adds an add/sub mode, leading-zero normalisation after cancellation, round-to-nearest-even, overflow/underflow flags and valid/ready flow control.
- Sits between an operand source and a result sink.
- Throughput is one operation per cycle; latency is 3 cycles.

Parameters:
- EXP_W, 4, exponent field width.
- MAN_W, 3, stored fraction width. The hidden 1 is implicit. Word width W = 1+EXP_W+MAN_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts operands this cycle.
- op  input  1  0 = a+b, 1 = a-b.
- a  input  W  operand {sign, exp, frac}.
- b  input  W  operand {sign, exp, frac}.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- result  output  W  sum or difference.
- overflow  output  1  result saturated; qualified by out_valid.
- underflow  output  1  result flushed to zero; qualified by out_valid.

Behaviour:
- Reset: all stage valid bits cleared. out_valid=0, result=0, overflow=0, underflow=0; in_ready=1 once rst deasserts.
- Reset asserted mid-operation discards all in-flight items immediately (asynchronous).
- Pipeline advance: adv = !out_valid | out_ready; in_ready = adv.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - All three stages shift together on adv; bubbles propagate as invalid.
  - Stalled outputs (result, flags, out_valid) hold stable.
- Encoding:
  - exp==0 means zero; frac is ignored and there are no denormals.
  - Effective sign of b: sb = b[W-1]^op.
- Zero operands:
  - a zero: result = {sb, b[W-2:0]}.
  - b zero: result = a.
  - Both zero: sign = sa & sb, exp = 0, frac = 0.
  - Flags are 0 in all zero-operand cases.
- Stage 1 (align):
  - Larger magnitude ({exp,frac} compare) becomes X; the other becomes Y. On a tie, a is X.
  - Both mantissas are extended to {1, frac, G, R, S} (MAN_W+4 bits).
  - Y shifts right by d = expX-expY. Shifted-out bits OR into S.
  - If d >= MAN_W+4, Y becomes S=1 only.
- Stage 2 (add/sub):
  - Same effective signs: M = X+Y (MAN_W+5 bits).
  - Different signs: M = X-Y, which is never negative.
  - Result sign = sign of X. Exact cancellation (M==0) produces +0 with no flags.
- Stage 3 (normalise and round):
  - Carry out: shift right 1 (OR the dropped bit into S), exp+1.
  - Otherwise: shift left by leading-zero count lz, exp-lz.
  - If exp-lz < 1: result = {sign, 0...}, underflow=1.
  - Round to nearest even: round up if G & (R|S|LSB).
  - A rounding carry out of the mantissa gives frac=0, exp+1.
  - If the final exp > 2^EXP_W-1: result = {sign, all-ones exp, all-ones frac}, overflow=1.
- Flags are mutually exclusive and travel with their result.

Test Plan:
- Basic add, defaults:
  - a=0x28, b=0x28, op=0, out_ready=1 → result=0x30 exactly 3 cycles after acceptance; flags 0.
- Cancellation and underflow:
  - a=0x2C, b=0x2B, op=1 → 0x10.
  - a=0x0C, b=0x0B, op=1 → 0x00 with underflow=1.
  - a=0x2B, b=0x2B, op=1 → 0x00 with no flags.
- Rounding:
  - a=0x20 + b=0x0F → 0x22 (GRS=111, rounds up; plain truncation gives 0x21).
  - a=0x20 + b=0x0C → 0x22 (tie with odd LSB, rounds up).
  - a=0x28 + b=0x08 → 0x28 (tie with even LSB, stays).
- Overflow and zero operands:
  - 0x7F+0x7F → 0x7F with overflow=1.
  - a=0x00, b=0xAB, op=0 → 0xAB.
  - a=0x00, b=0xAB, op=1 → 0x2B.
- Back-pressure:
  - Stream 5 pairs back-to-back with out_ready=0 from cycle 2.
  - Required: in_ready=0 while out_valid & !out_ready; result held stable; no item lost or duplicated.
  - After out_ready=1, results emerge in issue order, one per cycle.
- Reset mid-flight:
  - Assert rst with 3 items in flight → out_valid, result and flags go to 0 without waiting for a clock edge.
  - After release, the first new pair appears 3 cycles after acceptance.
